power_integrator: RTL
=====================

POWER_INTEGRATOR -- requirements
Module: power_integrator

Interface
REQ-001 SHALL have parameter PW, default 32, meaning input power width (2x complex component width).
REQ-002 SHALL have parameter LOG2N, default 6, meaning window length N = 2^LOG2N samples; legal range 1..16.
REQ-003 SHALL have port clk  input  1  clock, all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port power_i  input  PW  unsigned magnitude-squared sample.
REQ-006 SHALL have port valid_i  input  1  power_i qualifier; no backpressure to upstream.
REQ-007 SHALL have port clear_i  input  1  synchronous window/flag clear.
REQ-008 SHALL have port mean_o  output  PW  window sum >> LOG2N (truncating).
REQ-009 SHALL have port peak_o  output  PW  maximum power_i within window.
REQ-010 SHALL have port valid_o  output  1  result valid, held until accepted.
REQ-011 SHALL have port ready_i  input  1  downstream accept.
REQ-012 SHALL have port overrun_o  output  1  sticky: unaccepted result overwritten.

Function
REQ-013 SHALL keep internal accumulator of width PW+LOG2N; no overflow possible for N full-scale samples.
REQ-014 SHALL keep sample counter 0..N-1, advancing only on cycles with valid_i=1; idle cycles change no state except output handshake.
REQ-015 On valid_i with count=0 SHALL load accumulator with power_i and peak with power_i (fresh window, no carry-over).
REQ-016 On valid_i with 0<count<N-1 SHALL add power_i to accumulator and update peak to max(peak, power_i), unsigned compare.
REQ-017 On valid_i with count=N-1 SHALL, next edge: mean_o <= (acc+power_i)[PW+LOG2N-1:LOG2N], peak_o <= max(peak,power_i), valid_o <= 1, count <= 0.
REQ-018 Latency SHALL be 1 cycle: valid_o rises on the edge that registers the Nth sample.
REQ-019 valid_o SHALL stay 1 and mean_o/peak_o stable until a cycle with valid_o=1 and ready_i=1; valid_o clears on that edge.
REQ-020 Handshake and new result on same edge SHALL leave valid_o=1 with new data; overrun_o unchanged.
REQ-021 New result while valid_o=1 and ready_i=0 SHALL overwrite mean_o/peak_o, keep valid_o=1, set overrun_o=1.
REQ-022 overrun_o SHALL stay 1 until clear_i or rst.
REQ-023 clear_i=1 SHALL, next edge, zero count, accumulator, peak, valid_o, overrun_o; mean_o/peak_o hold last values.
REQ-024 clear_i SHALL take priority over valid_i and ready_i same cycle; the coincident sample is discarded.
REQ-025 ready_i while valid_o=0 SHALL have no effect.

Reset
REQ-026 rst SHALL asynchronously force mean_o=0, peak_o=0, valid_o=0, overrun_o=0, count=0, accumulator=0, peak=0.
REQ-027 rst mid-window SHALL discard partial window; the first valid_i after release starts a new window at count=0.

Verification (PW=32, LOG2N=2, N=4)
REQ-028 ready_i=1; samples 1,2,3,4 back-to-back -> one cycle after sample 4: valid_o=1, mean_o=2, peak_o=4, overrun_o=0.
REQ-029 Four samples 0xFFFFFFFF with idle gaps between -> mean_o=0xFFFFFFFF, peak_o=0xFFFFFFFF; valid_o only after fourth sample.
REQ-030 ready_i=0; windows {8,8,8,8} then {4,0,0,0} -> after second: mean_o=1, peak_o=4, valid_o=1, overrun_o=1; ready_i=1 one cycle -> valid_o=0, overrun_o stays 1.
REQ-031 Samples 100,200 then clear_i with coincident sample 50, then 5,6,7,8 -> mean_o=6, peak_o=8, overrun_o=0.
REQ-032 rst pulse after samples 9,9,9 -> outputs 0 immediately; then 1,1,1,1 -> mean_o=1, peak_o=1.
REQ-033 valid_o=1, ready_i=1 in same cycle as fourth sample of next window -> valid_o remains 1 with new mean_o; overrun_o=0.

Source files
------------

// File: rtl/power_integrator.sv
// power_integrator: block integrator over windows of N = 2^LOG2N power samples.
// Each complete window yields a truncated mean and a peak value. The result is
// held behind a valid/ready handshake with no backpressure on the input, and a
// sticky overrun flag is set when an unaccepted result is overwritten.
module power_integrator #(
  parameter int unsigned PW    = 32,
  parameter int unsigned LOG2N = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] power_i,
  input  logic          valid_i,
  input  logic          clear_i,
  output logic [PW-1:0] mean_o,
  output logic [PW-1:0] peak_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          overrun_o
);

  localparam int unsigned AW = PW + LOG2N;
  localparam logic [LOG2N-1:0] LAST_IDX = '1;

  logic [LOG2N-1:0] count;
  logic [AW-1:0]    acc;
  logic [PW-1:0]    peak;

  logic             first_smp;
  logic             last_smp;
  logic [AW-1:0]    acc_base;
  logic [AW-1:0]    sum;
  logic [PW-1:0]    peak_base;
  logic [PW-1:0]    peak_max;

  // Running sum and peak including the current sample; a window's first
  // sample sees zero history so nothing carries over between windows.
  always_comb begin
    first_smp = (count == '0);
    last_smp  = (count == LAST_IDX);
    acc_base  = first_smp ? '0 : acc;
    peak_base = first_smp ? '0 : peak;
    sum       = acc_base + {{LOG2N{1'b0}}, power_i};
    peak_max  = (power_i > peak_base) ? power_i : peak_base;
  end

  // Window accumulation, result registers and output handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      acc       <= '0;
      peak      <= '0;
      mean_o    <= '0;
      peak_o    <= '0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else if (clear_i) begin
      count     <= '0;
      acc       <= '0;
      peak      <= '0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      if (valid_o && ready_i)
        valid_o <= 1'b0;
      if (valid_i) begin
        if (last_smp) begin
          // A completing window wins over a same-edge acceptance, so valid_o
          // stays high with fresh data; only an unaccepted result is an overrun.
          mean_o  <= sum[AW-1:LOG2N];
          peak_o  <= peak_max;
          valid_o <= 1'b1;
          if (valid_o && !ready_i)
            overrun_o <= 1'b1;
          count   <= '0;
          acc     <= '0;
          peak    <= '0;
        end else begin
          acc   <= sum;
          peak  <= peak_max;
          count <= count + LOG2N'(1);
        end
      end
    end
  end

endmodule
